// File: rtl/interval_timer.sv
// interval_timer: prescaled step counter with one-shot and periodic modes.
// Emits a terminal pulse and counts terminal events (saturating).
module interval_timer #(
  parameter int WIDTH         = 16,
  parameter int PRESCALE      = 1,
  parameter int DEFAULT_LIMIT = 10
) (
  input  logic             tick,
  input  logic             clear,
  input  logic             run,
  input  logic             periodic,
  input  logic             load,
  input  logic [WIDTH-1:0] limit_in,
  output logic [WIDTH-1:0] count,
  output logic             reached,
  output logic             pulse,
  output logic [7:0]       periods
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PONE = PW'(1);
  localparam logic [WIDTH-1:0] DEF  = WIDTH'(DEFAULT_LIMIT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       periods_q, periods_d;
  logic             step;
  logic [7:0]       periods_inc;

  assign step        = run && (presc_q == PMAX);
  assign periods_inc = (periods_q == 8'hFF) ? 8'hFF : periods_q + 8'd1;

  // Next-state: load > run low > counting (clear handled in the register)
  always_comb begin
    limit_d   = limit_q;
    mode_d    = mode_q;
    presc_d   = presc_q;
    count_d   = count_q;
    done_d    = done_q;
    pulse_d   = 1'b0;
    periods_d = periods_q;
    if (load) begin
      limit_d   = (limit_in == '0) ? ONE : limit_in;
      presc_d   = '0;
      count_d   = '0;
      done_d    = 1'b0;
      periods_d = '0;
    end else if (!run) begin
      mode_d    = periodic;
      presc_d   = '0;
      count_d   = '0;
      done_d    = 1'b0;
      periods_d = '0;
    end else begin
      presc_d = step ? '0 : presc_q + PONE;
      if (step) begin
        if (mode_q) begin
          if (count_q == limit_q - ONE) begin
            count_d   = '0;
            pulse_d   = 1'b1;
            periods_d = periods_inc;
          end else begin
            count_d = count_q + ONE;
          end
        end else if (count_q < limit_q) begin
          count_d = count_q + ONE;
          if (count_q + ONE == limit_q) begin
            done_d    = 1'b1;
            pulse_d   = 1'b1;
            periods_d = periods_inc;
          end
        end
      end
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge tick) begin
    if (clear) begin
      limit_q   <= DEF;
      mode_q    <= 1'b0;
      presc_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      pulse_q   <= 1'b0;
      periods_q <= '0;
    end else begin
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      done_q    <= done_d;
      pulse_q   <= pulse_d;
      periods_q <= periods_d;
    end
  end

  assign count   = count_q;
  assign pulse   = pulse_q;
  assign periods = periods_q;
  assign reached = done_q & run;

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scoreboard bench for interval_timer.
// Two instances (PRESCALE 1 and 4) share stimulus; a step-count model predicts outputs.
module tb_interval_timer;

  logic        tick = 1'b0;
  logic        clear, run, periodic, load;
  logic [15:0] limit_in;

  logic [15:0] a_count, b_count;
  logic        a_reached, b_reached, a_pulse, b_pulse;
  logic [7:0]  a_periods, b_periods;

  always #5 tick = ~tick;

  interval_timer #(.WIDTH(16), .PRESCALE(1), .DEFAULT_LIMIT(10)) u_a (
    .tick(tick), .clear(clear), .run(run), .periodic(periodic),
    .load(load), .limit_in(limit_in), .count(a_count),
    .reached(a_reached), .pulse(a_pulse), .periods(a_periods)
  );

  interval_timer #(.WIDTH(16), .PRESCALE(4), .DEFAULT_LIMIT(10)) u_b (
    .tick(tick), .clear(clear), .run(run), .periodic(periodic),
    .load(load), .limit_in(limit_in), .count(b_count),
    .reached(b_reached), .pulse(b_pulse), .periods(b_periods)
  );

  typedef struct {
    int cnt;
    bit pls;
    int per;
    bit rch;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t q[$];
  pair_t e;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: limit, mode and run-high edges since the sequence began
  int m_lim [2];
  bit m_mode[2];
  int m_n   [2];
  int m_p   [2] = '{1, 4};

  function automatic void chk(string nm, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endfunction

  function automatic exp_t mdl(int i, bit rn);
    exp_t r;
    int s, L;
    bit st;
    s  = m_n[i] / m_p[i];
    L  = m_lim[i];
    st = (m_n[i] > 0) && (m_n[i] % m_p[i] == 0);
    if (m_mode[i]) begin
      r.cnt = s % L;
      r.per = (s / L > 255) ? 255 : s / L;
      r.pls = st && (s % L == 0);
      r.rch = 1'b0;
    end else begin
      r.cnt = (s < L) ? s : L;
      r.per = (s >= L) ? 1 : 0;
      r.pls = st && (s == L);
      r.rch = (s >= L) && rn;
    end
    return r;
  endfunction

  task automatic cyc(bit c, bit l, int li, bit r, bit p);
    pair_t x;
    clear    = c;
    load     = l;
    limit_in = li[15:0];
    run      = r;
    periodic = p;
    @(posedge tick);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_lim[i]  = 10;
        m_mode[i] = 1'b0;
        m_n[i]    = 0;
      end else if (l) begin
        m_lim[i] = (li[15:0] == 16'd0) ? 1 : int'(li[15:0]);
        m_n[i]   = 0;
      end else if (!r) begin
        m_n[i]    = 0;
        m_mode[i] = p;
      end else begin
        m_n[i]++;
      end
    end
    x.a = mdl(0, r);
    x.b = mdl(1, r);
    q.push_back(x);
    @(negedge tick);
    #1;
  endtask

  task automatic run_n(int n, bit p);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 1'b1, p);
  endtask

  // Monitor: every output cycle pops one expectation and compares
  always @(negedge tick) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("a.count",   int'(a_count),   e.a.cnt);
      chk("a.pulse",   int'(a_pulse),   int'(e.a.pls));
      chk("a.periods", int'(a_periods), e.a.per);
      chk("a.reached", int'(a_reached), int'(e.a.rch));
      chk("b.count",   int'(b_count),   e.b.cnt);
      chk("b.pulse",   int'(b_pulse),   int'(e.b.pls));
      chk("b.periods", int'(b_periods), e.b.per);
      chk("b.reached", int'(b_reached), int'(e.b.rch));
    end
  end

  initial begin
    bit c, l, r, p;
    int li;

    // Reset, default one-shot
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_n(12, 1'b0);
    chk("os.count_hold", int'(a_count), 10);
    chk("os.periods_one", int'(a_periods), 1);
    chk("os.reached_pre", int'(a_reached), 1);
    run = 1'b0;
    #1;
    chk("os.reached_drop", int'(a_reached), 0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Periodic, L = 3
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_n(9, 1'b1);
    chk("per.periods3", int'(a_periods), 3);

    // Run drop mid-count, periodic toggle while running ignored
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_n(3, 1'b0);
    run_n(2, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_n(3, 1'b0);

    // Load during counting, then zero limit
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_n(7, 1'b0);
    cyc(1'b0, 1'b1, 4, 1'b1, 1'b0);
    run_n(5, 1'b0);
    cyc(1'b0, 1'b1, 0, 1'b1, 1'b0);
    run_n(3, 1'b0);

    // Prescale with L = 2, then L = 1 saturation
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_n(24, 1'b1);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_n(300, 1'b1);
    chk("sat.periods", int'(a_periods), 255);

    // Priority: clear over load over counting
    cyc(1'b1, 1'b1, 50, 1'b1, 1'b0);
    run_n(3, 1'b0);
    cyc(1'b0, 1'b1, 50, 1'b1, 1'b0);
    run_n(4, 1'b0);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 5);
      li = $urandom_range(0, 12);
      r  = ($urandom_range(0, 99) >= 8);
      p  = $urandom_range(0, 1);
      cyc(c, l, li, r, p);
    end

    @(negedge tick);
    #1;
    chk("queue.drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Parametrised successor to the single-threshold tick counter. It counts `tick` cycles, optionally through a prescaler, while `run` is high. It signals when a programmable limit is reached, either once (one-shot mode) or repeatedly (periodic mode), and counts completed periods. It sits beside the lab-board control logic as the general-purpose delay and rate generator.

## Interface
Parameters:
- `WIDTH`, 16: width of the count and limit; must be ≥ 2.
- `PRESCALE`, 1: number of `tick` cycles per count step; must be ≥ 1.
- `DEFAULT_LIMIT`, 10: limit value after `clear`; must be in 1..2^WIDTH-1.

Ports:
- `tick`  in  1  clock; all state changes on its rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `run`  in  1  enable; low holds the block idle and cleared.
- `periodic`  in  1  mode select (1 = periodic, 0 = one-shot); sampled only while `run` = 0.
- `load`  in  1  one-cycle strobe; writes `limit_in` into the limit register.
- `limit_in`  in  WIDTH  new limit value.
- `count`  out  WIDTH  current step count.
- `reached`  out  1  one-shot done flag, gated by `run`.
- `pulse`  out  1  one-cycle terminal-event strobe.
- `periods`  out  8  number of terminal events, saturating.

## Operation
- Internal registers:
  - `limit` (WIDTH).
  - `mode` (1 bit).
  - `presc`, counting 0..PRESCALE-1, width clog2(PRESCALE) (minimum 1).
  - `count`.
  - `done` (1 bit).
  - `pulse`.
  - `periods`.
- Priority per edge is `clear` > `load` > `run` = 0 > counting.
- `clear`:
  - `limit` = DEFAULT_LIMIT, `mode` = 0.
  - `presc`, `count`, `done`, `pulse`, `periods` = 0.
- `load`:
  - `limit` = `limit_in`; a `limit_in` of 0 loads as 1.
  - `presc`, `count`, `done`, `pulse`, `periods` = 0.
  - The new limit takes effect on the next edge.
- `run` = 0:
  - `presc`, `count`, `done`, `pulse`, `periods` = 0.
  - `mode` = `periodic`.
- Step event: `run` = 1 and `presc` == PRESCALE-1.
  - `presc` increments on every `run`-high edge and wraps to 0 on a step.
  - With PRESCALE = 1, every `run`-high edge is a step.
- One-shot mode (`mode` = 0):
  - On a step with `count` < `limit`, `count` increments.
  - On the step where `count` becomes `limit`: `done` = 1 and `pulse` = 1 for that one cycle.
  - Afterwards `count` holds at `limit`; further steps have no effect and produce no further pulses.
- Periodic mode (`mode` = 1):
  - On a step with `count` == `limit`-1 (the terminal step): `count` = 0, `pulse` = 1 for one cycle, and `periods` increments, saturating at 255.
  - Any other step increments `count`.
  - `done` stays 0.
- `pulse` is deasserted on every edge that is not a terminal step. With `limit` = 1 and PRESCALE = 1 in periodic mode, `pulse` stays high continuously.
- `reached` = `done` & `run`. This is the only combinational output path, so `reached` drops in the same cycle `run` falls.
- `periods` is also incremented by the one-shot terminal event, so it reads 1 after a one-shot completes.
- Changing `periodic` while `run` = 1 has no effect until `run` has been low for at least one edge.

## Timing
- Reset values:
  - `count` = 0, `reached` = 0, `pulse` = 0, `periods` = 0.
  - `limit` = DEFAULT_LIMIT.
- Latency, PRESCALE = 1: if `run` is first sampled high at edge 1, then `count` = k after edge k. For limit L:
  - One-shot: `pulse` and `reached` go high after edge L.
  - Periodic: `pulse` is high after edges L, 2L, 3L, …
- General PRESCALE P: the first step occurs at edge P, and terminal events occur every L·P edges.
- Falling `run`: `reached` goes low immediately; all other outputs clear at the next edge.
- A `load` during counting restarts the sequence: the first step comes P edges after the `load` edge.
- `count` never wraps in one-shot mode. In periodic mode it never exceeds `limit`-1.

## Test plan
- Reset and default one-shot: one cycle of `clear`, then `run` = 1, `periodic` = 0, PRESCALE = 1 -> `count` reads 1..10 over 10 edges; `reached` and `pulse` go high after edge 10; `pulse` returns low after edge 11; `count` holds at 10; `periods` = 1.
- Periodic: load L = 3, `periodic` = 1, `run` = 1 for 9 edges -> `count` sequence 1,2,0,1,2,0,1,2,0; `pulse` high after edges 3, 6 and 9 only; `periods` = 3; `reached` stays 0.
- Run drop mid-count: one-shot, default limit, drop `run` when `count` = 5 -> `reached` stays 0; `count` = 0 on the next edge; re-asserting `run` counts from 1; a `periodic` toggle made while `run` was high is ignored.
- Load during counting and zero limit: load 4 while `count` = 7 -> `count` = 0 on the next edge, `reached` after 4 more edges; load 0 -> `limit` reads 1 and a one-shot completes after 1 edge.
- Prescale and saturation: PRESCALE = 4, periodic, L = 2 -> one `pulse` every 8 edges. Separately, PRESCALE = 1, L = 1 for 300 edges -> `pulse` continuously high and `periods` saturates at 255.
- Priority: assert `clear`, `load` (`limit_in` = 50) and `run` on the same edge -> `limit` = DEFAULT_LIMIT and all outputs 0; `load` with `run` = 1 takes precedence over counting.
